// File: rtl/lab_alu_pipe_if.sv
// Operand/result handshake bundle for the lab ALU pipe.
// master drives operands and accepts results; slave is the ALU.
interface lab_alu_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             flag_z;
    logic             flag_c;
    logic             flag_v;

    modport master (
        output in_valid, op, a, b, acc_clr, out_ready,
        input  in_ready, out_valid, out,
        input  flag_z, flag_c, flag_v
    );

    modport slave (
        input  in_valid, op, a, b, acc_clr, out_ready,
        output in_ready, out_valid, out,
        output flag_z, flag_c, flag_v
    );
endinterface

// File: rtl/lab_alu_pipe.sv
// WIDTH-bit 8-op ALU, one registered output stage, accumulator.
// Optional flags: define LAB_ALU_FLAGS_EN to build flag_z/c/v.
module lab_alu_pipe #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
    input logic           clk,
    input logic           rst,
    lab_alu_pipe_if.slave bus
);
    localparam logic [2:0] OP_XOR  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_ADD  = 3'd4;
    localparam logic [2:0] OP_SUB  = 3'd5;
    localparam logic [2:0] OP_PASS = 3'd6;
    localparam logic [2:0] OP_ACC  = 3'd7;

    localparam int MSB = WIDTH - 1;

    logic             accept;
    logic [WIDTH-1:0] acc_base;
    logic [WIDTH:0]   res;
    logic             ovf;

    logic             out_valid_q;
    logic             out_valid_d;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;

    // The single output slot frees up when the sink takes it.
    assign bus.in_ready  = !out_valid_q || bus.out_ready;
    assign accept        = bus.in_valid && bus.in_ready;
    assign acc_base      = bus.acc_clr ? ACC_INIT : acc_acc_sel();
    assign bus.out_valid = out_valid_q;
    assign bus.out       = out_q;

    function automatic logic [WIDTH-1:0] acc_acc_sel();
        return acc_q;
    endfunction

    // Op datapath: WIDTH+1-bit result, top bit is carry/borrow.
    always_comb begin
        res = '0;
        ovf = 1'b0;
        unique case (bus.op)
            OP_XOR:  res = {1'b0, bus.a ^ bus.b};
            OP_OR:   res = {1'b0, bus.a | bus.b};
            OP_AND:  res = {1'b0, bus.a & bus.b};
            OP_NAND: res = {1'b0, ~(bus.a & bus.b)};
            OP_ADD: begin
                res = {1'b0, bus.a} + {1'b0, bus.b};
                ovf = (bus.a[MSB] == bus.b[MSB])
                   && (res[MSB] != bus.a[MSB]);
            end
            OP_SUB: begin
                res = {1'b0, bus.a} - {1'b0, bus.b};
                ovf = (bus.a[MSB] != bus.b[MSB])
                   && (res[MSB] != bus.a[MSB]);
            end
            OP_PASS: res = {1'b0, bus.a};
            OP_ACC: begin
                res = {1'b0, acc_base} + {1'b0, bus.a};
                ovf = (acc_base[MSB] == bus.a[MSB])
                   && (res[MSB] != bus.a[MSB]);
            end
        endcase
    end

    // Output slot and accumulator next state.
    always_comb begin
        out_valid_d = out_valid_q;
        out_d       = out_q;
        acc_d       = acc_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_d       = res[MSB:0];
            if (bus.op == OP_ACC) begin
                acc_d = res[MSB:0];
            end else if (bus.acc_clr) begin
                acc_d = ACC_INIT;
            end
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; reset beats a same-cycle accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            acc_q       <= ACC_INIT;
        end else begin
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            acc_q       <= acc_d;
        end
    end

`ifdef LAB_ALU_FLAGS_EN
    logic [2:0] flags_q;
    logic [2:0] flags_d;

    // Flags {z,c,v} load together with the result.
    always_comb begin
        flags_d = flags_q;
        if (accept) begin
            flags_d = {res[MSB:0] == '0, res[WIDTH], ovf};
        end
    end

    // Flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign bus.flag_z = flags_q[2];
    assign bus.flag_c = flags_q[1];
    assign bus.flag_v = flags_q[0];
`else
    logic unused_flags;
    assign unused_flags = ^{res[WIDTH], ovf};
    assign bus.flag_z   = 1'b0;
    assign bus.flag_c   = 1'b0;
    assign bus.flag_v   = 1'b0;
`endif
endmodule

// File: tb/tb_lab_alu_pipe.sv
// Bench for lab_alu_pipe: directed literals plus random traffic
// against an integer-arithmetic model with a result queue.
module tb_lab_alu_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lab_alu_pipe_if #(.WIDTH(8)) bus();

    lab_alu_pipe #(
        .WIDTH(8),
        .ACC_INIT(8'h00)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

`ifdef LAB_ALU_FLAGS_EN
    localparam bit FL = 1'b1;
`else
    localparam bit FL = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] r;
        logic [2:0] f;
    } res_t;

    res_t q[$];
    res_t last;
    int   acc_m;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h",
                     nm, act, exp);
        end
    endtask

    function automatic bit sovf(input int s);
        return (s > 127) || (s < -128);
    endfunction

    function automatic int sx8(input int v);
        return (v > 127) ? v - 256 : v;
    endfunction

    // Spec-level model of one accepted operation.
    function automatic void mdl(
        input  logic [2:0] o,
        input  logic [7:0] x,
        input  logic [7:0] y,
        input  bit         clr,
        input  int         acc_in,
        output int         acc_out,
        output res_t       e
    );
        int xi, yi, s, base;
        bit c, v;
        xi = int'(x);
        yi = int'(y);
        base = clr ? 0 : acc_in;
        acc_out = base;
        c = 1'b0;
        v = 1'b0;
        s = 0;
        case (o)
            3'd0: s = xi ^ yi;
            3'd1: s = xi | yi;
            3'd2: s = xi & yi;
            3'd3: s = 255 - (xi & yi);
            3'd4: begin
                s = xi + yi;
                c = s > 255;
                v = sovf(sx8(xi) + sx8(yi));
            end
            3'd5: begin
                s = xi - yi + 256;
                c = xi < yi;
                v = sovf(sx8(xi) - sx8(yi));
            end
            3'd6: s = xi;
            default: begin
                s = base + xi;
                c = s > 255;
                v = sovf(sx8(base) + sx8(xi));
                acc_out = s % 256;
            end
        endcase
        e.r = 8'(s % 256);
        e.f = FL ? {e.r == 8'h00, c, v} : 3'b000;
    endfunction

    // Compare process: every cycle out of reset, check the output
    // slot against the model queue, then apply this edge's transfers.
    always @(negedge clk) begin
        res_t e;
        res_t n;
        int   na;
        bit   fin;
        bit   fout;
        bit   rdy;
        if (rst) begin
            q.delete();
            acc_m = 0;
            last.r = 8'h00;
            last.f = 3'b000;
        end else begin
            rdy = (q.size() == 0) || bus.out_ready;
            chk("in_ready", bus.in_ready, rdy);
            if (q.size() > 0) begin
                e = q[0];
                chk("out_valid", bus.out_valid, 1);
            end else begin
                e = last;
                chk("out_valid", bus.out_valid, 0);
            end
            chk("out", bus.out, e.r);
            chk("flags",
                {bus.flag_z, bus.flag_c, bus.flag_v}, e.f);
            fout = (q.size() > 0) && bus.out_ready;
            fin  = bus.in_valid && rdy;
            if (fout) last = q.pop_front();
            if (fin) begin
                mdl(bus.op, bus.a, bus.b, bus.acc_clr,
                    acc_m, na, n);
                acc_m = na;
                q.push_back(n);
            end
        end
    end

    // One accepted op with out_ready=1; result checked 1 cycle on.
    task automatic do_op(input string nm,
                         input logic [2:0] o,
                         input logic [7:0] x,
                         input logic [7:0] y,
                         input bit clr,
                         input logic [7:0] eo,
                         input logic [2:0] ef);
        bus.in_valid = 1'b1;
        bus.op = o;
        bus.a = x;
        bus.b = y;
        bus.acc_clr = clr;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.acc_clr = 1'b0;
        chk({nm, "_valid"}, bus.out_valid, 1);
        chk(nm, bus.out, eo);
        chk({nm, "_flags"},
            {bus.flag_z, bus.flag_c, bus.flag_v},
            FL ? ef : 3'b000);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.op = 3'd0;
        bus.a = 8'h00;
        bus.b = 8'h00;
        bus.acc_clr = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out", bus.out, 8'h00);
        chk("rst_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;

        // Legacy logic ops, back to back.
        do_op("xor", 3'd0, 8'hF0, 8'h3C, 0, 8'hCC, 3'b000);
        do_op("or", 3'd1, 8'hF0, 8'h3C, 0, 8'hFC, 3'b000);
        do_op("and", 3'd2, 8'hF0, 8'h3C, 0, 8'h30, 3'b000);
        do_op("nand", 3'd3, 8'hF0, 8'h3C, 0, 8'hCF, 3'b000);

        // Arithmetic and flags.
        do_op("add_wrap", 3'd4, 8'hFF, 8'h01, 0, 8'h00, 3'b110);
        do_op("add_ovf", 3'd4, 8'h7F, 8'h01, 0, 8'h80, 3'b001);
        do_op("sub_brw", 3'd5, 8'h03, 8'h05, 0, 8'hFE, 3'b010);
        do_op("pass", 3'd6, 8'h5A, 8'hFF, 0, 8'h5A, 3'b000);

        // Accumulator.
        do_op("acc1", 3'd7, 8'h80, 8'h00, 0, 8'h80, 3'b000);
        do_op("acc2", 3'd7, 8'h80, 8'h00, 0, 8'h00, 3'b111);
        do_op("acc3", 3'd7, 8'h80, 8'h00, 0, 8'h80, 3'b000);
        do_op("acc_clr", 3'd7, 8'h05, 8'h00, 1, 8'h05, 3'b000);
        do_op("acc_ff", 3'd7, 8'hFF, 8'h00, 1, 8'hFF, 3'b000);
        do_op("acc_wrap", 3'd7, 8'h01, 8'h00, 0, 8'h00, 3'b110);
        do_op("clr_xor", 3'd0, 8'h0F, 8'h01, 1, 8'h0E, 3'b000);
        do_op("acc_after", 3'd7, 8'h09, 8'h00, 0, 8'h09, 3'b000);

        // Backpressure: result held, next op waits, then lands.
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.op = 3'd4;
        bus.a = 8'h01;
        bus.b = 8'h02;
        @(posedge clk);
        #1;
        bus.op = 3'd0;
        bus.a = 8'h05;
        bus.b = 8'h03;
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready", bus.in_ready, 0);
            chk("bp_out", bus.out, 8'h03);
            chk("bp_valid", bus.out_valid, 1);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release", bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("bp_next", bus.out, 8'h06);
        chk("bp_next_valid", bus.out_valid, 1);
        @(posedge clk);
        #1;

        // Reset while stalled; acc must come back to zero.
        do_op("acc_pre", 3'd7, 8'h22, 8'h00, 1, 8'h22, 3'b000);
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.op = 3'd4;
        bus.a = 8'h01;
        bus.b = 8'h02;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        chk("rst2_valid", bus.out_valid, 0);
        chk("rst2_out", bus.out, 8'h00);
        chk("rst2_in_ready", bus.in_ready, 1);
        do_op("acc_rst", 3'd7, 8'h00, 8'h00, 0, 8'h00, 3'b100);

        // Random traffic checked by the compare process.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            rst = ($urandom_range(0, 127) == 0);
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.op = 3'($urandom_range(0, 7));
            bus.a = 8'($urandom);
            bus.b = 8'($urandom);
            bus.acc_clr = ($urandom_range(0, 7) == 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("drain_empty", q.size(), 0);
        chk("drain_valid", bus.out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
